// File: rtl/spi_pkg.sv
// Shared sizes, state encoding and a small helper for the SPI controller slice.
package spi_pkg;

  localparam int WORD_W = 16;
  localparam int DIV_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_t;

  // Terminal count of a half-period counter for a given divider setting.
  function automatic logic [DIV_W-1:0] div_last(input int half_div);
    return DIV_W'(half_div - 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every HALF_DIV clocks while enabled.
module spi_clk_div #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tick
);
  import spi_pkg::*;

  localparam logic [DIV_W-1:0] LAST_C = div_last(HALF_DIV);
  localparam logic [DIV_W-1:0] ONE_C  = DIV_W'(1);

  logic [DIV_W-1:0] cnt_r;

  // Half-period counter; parked at zero while disabled so every enable starts a full period.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (!en) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (cnt_r == LAST_C) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  assign tick = en && (cnt_r == LAST_C);

endmodule

// File: rtl/spi_controller.sv
// SPI master, mode 0: one word per transfer, MSB first, framed by cs_n with setup/hold/gap phases.
module spi_controller #(
  parameter int HALF_DIV = 4,
  parameter int WORD_W   = spi_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi,
  output logic              cs_n
);
  import spi_pkg::*;

  localparam int               BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] ONE_BIT  = BIT_W'(1);

  spi_state_t        state_r;
  spi_state_t        state_s;
  logic [WORD_W-1:0] tx_sh_r;
  logic [WORD_W-1:0] rx_sh_r;
  logic [WORD_W-1:0] rx_data_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              sclk_r;
  logic              cs_n_r;
  logic              tx_ready_r;
  logic              rx_valid_r;
  logic              div_en_s;
  logic              tick_s;
  logic              accept_s;
  logic              rise_s;
  logic              fall_s;
  logic              finish_s;

  // Every phase lasts a whole number of half-periods, so the divider free-runs until IDLE.
  assign div_en_s = (state_r != IDLE);

  spi_clk_div #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_div (
    .clk    (clk),
    .resetn (resetn),
    .en     (div_en_s),
    .tick   (tick_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    rise_s   = 1'b0;
    fall_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_valid && tx_ready_r) begin
          accept_s = 1'b1;
          state_s  = SETUP;
        end else begin
          state_s  = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_s = SHIFT;
        end else begin
          state_s = SETUP;
        end
      end
      SHIFT: begin
        rise_s = tick_s && !sclk_r;
        fall_s = tick_s && sclk_r;
        if (fall_s && (bit_cnt_r == LAST_BIT)) begin
          state_s = HOLD;
        end else begin
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (tick_s) begin
          finish_s = 1'b1;
          state_s  = GAP;
        end else begin
          state_s  = HOLD;
        end
      end
      GAP: begin
        if (tick_s) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Serial datapath and registered interface outputs; sdo is the MSB of the tx shifter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_sh_r    <= {WORD_W{1'b0}};
      rx_sh_r    <= {WORD_W{1'b0}};
      rx_data_r  <= {WORD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      sclk_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      tx_ready_r <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      tx_ready_r <= (state_s == IDLE);
      rx_valid_r <= finish_s;
      if (accept_s) begin
        tx_sh_r   <= tx_data;
        rx_sh_r   <= {WORD_W{1'b0}};
        bit_cnt_r <= {BIT_W{1'b0}};
        cs_n_r    <= 1'b0;
      end else if (rise_s) begin
        sclk_r  <= 1'b1;
        rx_sh_r <= {rx_sh_r[WORD_W-2:0], sdi};
      end else if (fall_s) begin
        sclk_r    <= 1'b0;
        bit_cnt_r <= bit_cnt_r + ONE_BIT;
        // The last falling edge leaves bit 0 on sdo through HOLD.
        if (bit_cnt_r != LAST_BIT) begin
          tx_sh_r <= {tx_sh_r[WORD_W-2:0], 1'b0};
        end else begin
          tx_sh_r <= tx_sh_r;
        end
      end else if (finish_s) begin
        cs_n_r    <= 1'b1;
        tx_sh_r   <= {WORD_W{1'b0}};
        rx_data_r <= rx_sh_r;
      end else begin
        sclk_r <= sclk_r;
      end
    end
  end

  assign tx_ready = tx_ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign sclk     = sclk_r;
  assign sdo      = tx_sh_r[WORD_W-1];
  assign cs_n     = cs_n_r;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: table of single-word transfers at HALF_DIV=2, back-to-back at HALF_DIV=1, mid-transfer reset.
module tb_spi_controller;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // DUT with HALF_DIV=2; sdi source selectable: 0 -> 0, 1 -> 1, 2 -> loopback of sdo
  logic [15:0] tx_data2 = 16'h0000;
  logic        tx_valid2 = 1'b0;
  logic        tx_ready2, rx_valid2, sclk2, sdo2, sdi2, cs_n2;
  logic [15:0] rx_data2;
  logic [1:0]  sdi_mode = 2'd0;
  assign sdi2 = (sdi_mode == 2'd2) ? sdo2 : sdi_mode[0];

  // DUT with HALF_DIV=1 in permanent loopback
  logic [15:0] tx_data1 = 16'h0000;
  logic        tx_valid1 = 1'b0;
  logic        tx_ready1, rx_valid1, sclk1, sdo1, sdi1, cs_n1;
  logic [15:0] rx_data1;
  assign sdi1 = sdo1;

  spi_controller #(.HALF_DIV(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .sclk(sclk2), .sdo(sdo2), .sdi(sdi2), .cs_n(cs_n2)
  );

  spi_controller #(.HALF_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .sclk(sclk1), .sdo(sdo1), .sdi(sdi1), .cs_n(cs_n1)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [1:0]  mode;
    logic        chg;
    logic [15:0] exp_sdo;
    logic [15:0] exp_rx;
    logic        exp_sdo_hi;
  } vec_t;

  vec_t vecs[6];

  // One transfer on the HALF_DIV=2 DUT: cs_n low 34*2=68, busy 35*2=70 cycles, rx_valid on cs_n rise
  task automatic run_vec(input int idx, input vec_t v);
    int guard;
    int low_cnt;
    int rise_cnt;
    int rxv_cnt;
    int busy_cnt;
    logic [15:0] sdo_bits;
    logic [15:0] rx_cap;
    logic prev_sclk;
    logic prev_cs;
    logic rxv_edge_ok;
    logic sdo_hi;
    guard = 0;
    while (tx_ready2 !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d ready_before", idx), 32'(tx_ready2), 32'd1);
    sdi_mode  = v.mode;
    tx_data2  = v.word;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    low_cnt = 0; rise_cnt = 0; rxv_cnt = 0; busy_cnt = 0;
    sdo_bits = 16'h0000; rx_cap = 16'h0000;
    prev_sclk = 1'b0; prev_cs = 1'b1; rxv_edge_ok = 1'b0; sdo_hi = 1'b0;
    guard = 0;
    while (tx_ready2 !== 1'b1 && guard < 200) begin
      busy_cnt++;
      if (cs_n2 == 1'b0) low_cnt++;
      if (sdo2 == 1'b1) sdo_hi = 1'b1;
      if (sclk2 && !prev_sclk) begin
        rise_cnt++;
        sdo_bits = {sdo_bits[14:0], sdo2};
        if (v.chg && rise_cnt == 3) begin
          tx_data2  = 16'h1234;
          tx_valid2 = 1'b1;
        end
      end
      if (rx_valid2) begin
        rxv_cnt++;
        rx_cap = rx_data2;
        rxv_edge_ok = cs_n2 && !prev_cs;
      end
      prev_sclk = sclk2;
      prev_cs   = cs_n2;
      @(negedge clk);
      guard++;
    end
    tx_valid2 = 1'b0;
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt), 32'd70);
    check($sformatf("v%0d sdo_bits", idx), 32'(sdo_bits), 32'(v.exp_sdo));
    check($sformatf("v%0d cs_low_cycles", idx), 32'(low_cnt), 32'd68);
    check($sformatf("v%0d sclk_rises", idx), 32'(rise_cnt), 32'd16);
    check($sformatf("v%0d rx_valid_cycles", idx), 32'(rxv_cnt), 32'd1);
    check($sformatf("v%0d rx_data", idx), 32'(rx_cap), 32'(v.exp_rx));
    check($sformatf("v%0d rx_valid_on_cs_rise", idx), 32'(rxv_edge_ok), 32'd1);
    check($sformatf("v%0d sdo_ever_high", idx), 32'(sdo_hi), 32'(v.exp_sdo_hi));
    repeat (5) @(negedge clk);
    check($sformatf("v%0d rx_data_hold", idx), 32'(rx_data2), 32'(v.exp_rx));
    check($sformatf("v%0d idle_sdo", idx), 32'(sdo2), 32'd0);
    check($sformatf("v%0d idle_cs_n", idx), 32'(cs_n2), 32'd1);
  endtask

  initial begin
    int guard;
    int low_cnt;
    int rise_cnt;
    int rxw_cnt;
    int gap_cnt;
    logic [31:0] sdo_bits;
    logic [15:0] rxw[2];
    logic prev_sclk;
    logic swapped;

    //          word      mode  chg   exp_sdo   exp_rx    sdo_hi
    vecs[0] = '{16'h00B4, 2'd0, 1'b0, 16'h00B4, 16'h0000, 1'b1};
    vecs[1] = '{16'hA5C3, 2'd2, 1'b0, 16'hA5C3, 16'hA5C3, 1'b1};
    vecs[2] = '{16'h0000, 2'd1, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[3] = '{16'hFFFF, 2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8001, 2'd2, 1'b0, 16'h8001, 16'h8001, 1'b1};
    vecs[5] = '{16'h8000, 2'd2, 1'b1, 16'h8000, 16'h8000, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tx_ready", 32'(tx_ready2), 32'd0);
    check("rst cs_n", 32'(cs_n2), 32'd1);
    check("rst sclk", 32'(sclk2), 32'd0);
    check("rst sdo", 32'(sdo2), 32'd0);
    check("rst rx_valid", 32'(rx_valid2), 32'd0);
    check("rst rx_data", 32'(rx_data2), 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst release tx_ready2", 32'(tx_ready2), 32'd1);
    check("rst release tx_ready1", 32'(tx_ready1), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // HALF_DIV=1, tx_valid held: 0001 then FFFF; cs_n high = GAP (1) + IDLE accept cycle (1)
    tx_data1 = 16'h0001;
    tx_valid1 = 1'b1;
    @(negedge clk);
    low_cnt = 0; rise_cnt = 0; rxw_cnt = 0; gap_cnt = 0;
    sdo_bits = 32'h0; rxw[0] = 16'h0; rxw[1] = 16'h0;
    prev_sclk = 1'b0; swapped = 1'b0; guard = 0;
    while (rxw_cnt < 2 && guard < 150) begin
      if (!swapped) begin
        tx_data1 = 16'hFFFF;
        swapped = 1'b1;
      end
      if (cs_n1 == 1'b0) low_cnt++;
      if (sclk1 && !prev_sclk) begin
        rise_cnt++;
        sdo_bits = {sdo_bits[30:0], sdo1};
      end
      if (rx_valid1) begin
        rxw[rxw_cnt[0]] = rx_data1;
        rxw_cnt++;
      end
      if (cs_n1 == 1'b1 && rxw_cnt == 1) gap_cnt++;
      prev_sclk = sclk1;
      if (rxw_cnt == 2) tx_valid1 = 1'b0;
      @(negedge clk);
      guard++;
    end
    tx_valid1 = 1'b0;
    check("b2b words_received", 32'(rxw_cnt), 32'd2);
    check("b2b rx_word0", 32'(rxw[0]), 32'h0001);
    check("b2b rx_word1", 32'(rxw[1]), 32'hFFFF);
    check("b2b sdo_bits", sdo_bits, 32'h0001FFFF);
    check("b2b sclk_rises", 32'(rise_cnt), 32'd32);
    check("b2b cs_low_cycles", 32'(low_cnt), 32'd68);
    check("b2b cs_high_gap", 32'(gap_cnt), 32'd2);
    repeat (3) @(negedge clk);
    check("b2b no_third cs_n", 32'(cs_n1), 32'd1);
    check("b2b idle tx_ready", 32'(tx_ready1), 32'd1);

    // Reset after the 5th rising sclk aborts the word with no rx_valid
    sdi_mode = 2'd2;
    tx_data2 = 16'hFFFF;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    rise_cnt = 0; prev_sclk = 1'b0; guard = 0;
    while (rise_cnt < 5 && guard < 100) begin
      @(negedge clk);
      if (sclk2 && !prev_sclk) rise_cnt++;
      prev_sclk = sclk2;
      guard++;
    end
    check("abort reached_5th_rise", 32'(rise_cnt), 32'd5);
    resetn = 1'b0;
    @(negedge clk);
    check("abort cs_n", 32'(cs_n2), 32'd1);
    check("abort sclk", 32'(sclk2), 32'd0);
    check("abort sdo", 32'(sdo2), 32'd0);
    check("abort rx_valid", 32'(rx_valid2), 32'd0);
    check("abort tx_ready", 32'(tx_ready2), 32'd0);
    check("abort rx_data", 32'(rx_data2), 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("abort release tx_ready", 32'(tx_ready2), 32'd1);
    rise_cnt = 0;
    gap_cnt = 0;
    repeat (80) begin
      if (rx_valid2) rise_cnt++;
      if (cs_n2 == 1'b0) gap_cnt++;
      @(negedge clk);
    end
    check("abort no_rx_valid", 32'(rise_cnt), 32'd0);
    check("abort word_dropped", 32'(gap_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
